// File: rtl/fifo_rd_stream_adapter_pkg.sv
// fifo_rd_stream_adapter_pkg: shared widths, FIFO read latency and the read-credit helper
package fifo_rd_stream_adapter_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_RD_LAT = 1;
  // A pop can only happen with occ >= 1, so the subtraction never underflows.
  function automatic logic credit_ok(input logic [1:0] occ, input logic pend, input logic pop);
    return ({1'b0, occ} + {2'b0, pend} - {2'b0, pop}) < 3'd2;
  endfunction
endpackage

// File: rtl/fifo_rd_stream_adapter_skid_buf2.sv
// fifo_rd_stream_adapter_skid_buf2: 2-entry FIFO-ordered register buffer with registered head
module fifo_rd_stream_adapter_skid_buf2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [1:0]   occ_o,
  output logic [W-1:0] head_o
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic head_q, head_d, tail;
  logic [1:0] occ_q, occ_d;
  // With occ==2 the tail is the head slot, which is only refilled as it is popped.
  always_comb begin
    tail = head_q ^ occ_q[0];
    mem_d = mem_q;
    if (push_i) mem_d[tail] = push_data_i;
    head_d = head_q ^ pop_i;
    occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      head_q <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      head_q <= head_d;
      occ_q <= occ_d;
    end
  end
  assign occ_o = occ_q;
  assign head_o = mem_q[head_q];
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: drives FIFO reads from its empty flag and re-times words into a valid/ready stream
module fifo_rd_stream_adapter
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_e,
  input  logic [DATA_W-1:0] fifo_data_out,
  output logic              fifo_cs,
  output logic              fifo_rd_enb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  word_cnt
);
  logic [1:0] occ;
  logic pop, pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fifo_rd_stream_adapter_skid_buf2 #(.W(DATA_W)) u_buf (
    .clk(clk),
    .rst(rst),
    .push_i(pend_q),
    .push_data_i(fifo_data_out),
    .pop_i(pop),
    .occ_o(occ),
    .head_o(m_data)
  );
  assign m_valid = occ != 2'd0;
  assign pop = m_valid & m_ready;
  // Counting the same-cycle pop as credit keeps 1 word/cycle with only two entries.
  assign fifo_rd_enb = !rst && !fifo_e && credit_ok(occ, pend_q, pop);
  assign fifo_cs = fifo_rd_enb;
  assign word_cnt = cnt_q;
  always_comb begin
    pend_d = fifo_rd_enb;
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ({1'b0, occ} + {2'b0, pend_q} <= 3'd2);
      assert (!(pend_q && occ == 2'd2 && !pop));
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: directed bench with a depth-8 registered-read FIFO model in front of the adapter
module tb_fifo_rd_stream_adapter;
  logic clk = 1'b0, rst, fifo_e, fifo_cs, fifo_rd_enb, m_valid, m_ready, wr_en;
  logic [31:0] fifo_data_out, m_data, wr_data;
  logic [15:0] word_cnt;
  logic [31:0] fmem [8];
  int fcnt, rp, wp;
  int checks = 0, errors = 0;
  int rdp = 0, vseen = 0, prun = 0, pmax = 0, r0, v0;
  logic live = 1'b0, rec = 1'b1;
  logic [31:0] got [$];
  logic [31:0] expq [$];
  logic rd_go, wr_go;

  fifo_rd_stream_adapter dut (
    .clk(clk),
    .rst(rst),
    .fifo_e(fifo_e),
    .fifo_data_out(fifo_data_out),
    .fifo_cs(fifo_cs),
    .fifo_rd_enb(fifo_rd_enb),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  assign fifo_e = (fcnt == 0);
  assign rd_go = fifo_rd_enb & fifo_cs & !fifo_e;
  assign wr_go = wr_en & (fcnt < 8);

  always @(posedge clk) begin
    if (rst) begin
      fcnt <= 0;
      rp <= 0;
      wp <= 0;
      fifo_data_out <= '0;
    end else begin
      if (rd_go) begin
        fifo_data_out <= fmem[rp];
        rp <= (rp + 1) % 8;
      end
      if (wr_go) begin
        fmem[wp] <= wr_data;
        wp <= (wp + 1) % 8;
      end
      fcnt <= fcnt + int'(wr_go) - int'(rd_go);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_got(input string tag, input logic [31:0] e [$]);
    chk({tag, "_len"}, 64'(got.size()), 64'(e.size()));
    for (int i = 0; i < e.size(); i++)
      chk(tag, i < got.size() ? got[i] : 32'hDEADBEEF, e[i]);
  endtask

  // One clock: sample at the falling edge, return just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    if (live && m_valid)
      chk("head", m_data, got.size() < expq.size() ? expq[got.size()] : 32'hDEADBEEF);
    if (m_valid && m_ready) begin
      if (rec) got.push_back(m_data);
      prun++;
      if (prun > pmax) pmax = prun;
    end else prun = 0;
    if (fifo_rd_enb) rdp++;
    if (m_valid) vseen++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] p;
    rst = 1'b1;
    m_ready = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    repeat (2) cycle();
    #2;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_rd", fifo_rd_enb, 0);
    // Basic stream and first-word latency
    rst = 1'b0;
    m_ready = 1'b1;
    wr_en = 1'b1;
    wr_data = 1;
    cycle();
    wr_data = 10;
    #2;
    chk("lat_e", fifo_e, 0);
    chk("lat_rd", fifo_rd_enb, 1);
    chk("lat_v0", m_valid, 0);
    cycle();
    wr_data = 100;
    #2;
    chk("lat_v1", m_valid, 0);
    cycle();
    wr_en = 1'b0;
    #2;
    chk("lat_v2", m_valid, 1);
    chk("lat_d2", m_data, 1);
    repeat (6) cycle();
    chk_got("basic", '{32'd1, 32'd10, 32'd100});
    chk("basic_cnt", word_cnt, 3);
    // Backpressure: only two words may leave the FIFO
    got.delete();
    r0 = rdp;
    m_ready = 1'b0;
    p = 1;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wr_data = p;
      p = p * 3;
      cycle();
    end
    wr_en = 1'b0;
    repeat (6) cycle();
    #2;
    chk("bp_pulses", rdp - r0, 2);
    chk("bp_occ", dut.occ, 2);
    chk("bp_fcnt", fcnt, 6);
    chk("bp_e", fifo_e, 0);
    chk("bp_rd", fifo_rd_enb, 0);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 1);
    m_ready = 1'b1;
    repeat (14) cycle();
    chk_got("bp", '{32'd1, 32'd3, 32'd9, 32'd27, 32'd81, 32'd243, 32'd729, 32'd2187});
    chk("bp_cnt", word_cnt, 11);
    // Full FIFO plus full buffer drains without bubbles
    got.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1;
      wr_data = 32'(100 + i);
      cycle();
    end
    wr_en = 1'b0;
    repeat (4) cycle();
    #2;
    chk("full_fcnt", fcnt, 8);
    chk("full_occ", dut.occ, 2);
    pmax = 0;
    m_ready = 1'b1;
    repeat (16) cycle();
    chk("full_run", pmax, 10);
    chk_got("full", '{32'd100, 32'd101, 32'd102, 32'd103, 32'd104,
                      32'd105, 32'd106, 32'd107, 32'd108, 32'd109});
    chk("full_cnt", word_cnt, 21);
    // Empty FIFO: nothing is read or presented
    r0 = rdp;
    v0 = vseen;
    repeat (10) cycle();
    chk("empty_rd", rdp - r0, 0);
    chk("empty_valid", vseen - v0, 0);
    // Toggled ready: head must match the next expected word every valid cycle
    got.delete();
    expq = '{32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd32, 32'd64, 32'd128};
    live = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wr_data = 32'd1 << i;
      m_ready = (i % 2 == 1);
      cycle();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 24; i++) begin
      m_ready = ~m_ready;
      cycle();
    end
    live = 1'b0;
    chk_got("tog", expq);
    chk("tog_cnt", word_cnt, 29);
    // Reset while a word is buffered and another is in flight
    m_ready = 1'b0;
    wr_en = 1'b1;
    wr_data = 32'hA;
    cycle();
    wr_data = 32'hB;
    cycle();
    wr_data = 32'hC;
    cycle();
    wr_en = 1'b0;
    #2;
    chk("mr_occ", dut.occ, 1);
    chk("mr_pend", dut.pend_q, 1);
    rst = 1'b1;
    cycle();
    #2;
    chk("mr_valid", m_valid, 0);
    chk("mr_rd", fifo_rd_enb, 0);
    chk("mr_cnt", word_cnt, 0);
    chk("mr_data", m_data, 0);
    rst = 1'b0;
    cycle();
    #2;
    chk("mr_valid2", m_valid, 0);
    chk("mr_cnt2", word_cnt, 0);
    // Counter wrap
    rec = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      wr_en = 1'b1;
      wr_data = 32'(i);
      cycle();
    end
    wr_en = 1'b0;
    repeat (8) cycle();
    chk("wrap_max", word_cnt, 16'hFFFF);
    chk("wrap_idle", m_valid, 0);
    wr_en = 1'b1;
    wr_data = 32'd7;
    cycle();
    wr_en = 1'b0;
    repeat (6) cycle();
    chk("wrap_zero", word_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
